dtw_tmpl_fetch: RTL and testbench

Template fetch stage for the DTW processor. It reads one stored template sequence (SEQ_LEN consecutive 32-bit words) from the single-port synchronous template memory and streams it to the DTW core over a valid/ready handshake. A 2-entry buffer absorbs the memory's 1-cycle read latency and core backpressure. It sits between the template memory port and the DTW core's template input, alongside the R-sequence input path.

---
 rtl/dtw_pkg.sv | 19 +
 rtl/dtw_tmpl_fetch_if.sv | 29 ++
 rtl/dtw_skid_fifo.sv | 66 ++++++
 rtl/dtw_tmpl_fetch.sv | 138 +++++++++++++
 tb/tb_dtw_tmpl_fetch.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW processor front end.
// Holds the memory geometry, template length, derived counter width and
// the fetch FSM state encoding.
package dtw_pkg;

    localparam int ADDR_W    = 10;               // template memory address width
    localparam int DATA_W    = 32;               // template word width
    localparam int SEQ_LEN   = 20;               // words per template
    localparam int IDX_W     = 6;                // template index width
    localparam int MEM_DEPTH = 1 << ADDR_W;      // words in template memory
    localparam int CNT_W     = $clog2(SEQ_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/dtw_tmpl_fetch_if.sv
// Bus bundle between the template fetch stage, the template memory and the
// DTW core template input.
//   mem_addr/mem_CS/mem_WR : fetch -> memory (CS active-low, WR=0 is read)
//   mem_rdata              : memory -> fetch
//   o_data/o_valid/o_last  : fetch -> core stream
//   i_ready                : core -> fetch
// master = fetch stage side, slave = memory + core side.
interface dtw_tmpl_fetch_if;

    logic [dtw_pkg::ADDR_W-1:0] mem_addr;
    logic                       mem_CS;
    logic                       mem_WR;
    logic [dtw_pkg::DATA_W-1:0] mem_rdata;
    logic [dtw_pkg::DATA_W-1:0] o_data;
    logic                       o_valid;
    logic                       o_last;
    logic                       i_ready;

    modport master (
        output mem_addr, mem_CS, mem_WR, o_data, o_valid, o_last,
        input  mem_rdata, i_ready
    );

    modport slave (
        input  mem_addr, mem_CS, mem_WR, o_data, o_valid, o_last,
        output mem_rdata, i_ready
    );

endinterface

// File: rtl/dtw_skid_fifo.sv
// 2-entry FIFO with registered output. Slot 0 is always the head, so dout
// comes straight from a flop. Push and pop in the same cycle are legal at
// any occupancy, including full; a push into a full FIFO without a pop is
// dropped, and a pop from an empty FIFO is ignored.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write strobe and data
//   pop        : consume the head entry
//   dout, valid: head entry and non-empty flag
//   count      : occupancy 0..2
module dtw_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] slot0, slot1;
    logic [1:0]   cnt;
    logic         do_pop, do_push;

    assign do_pop  = pop & (cnt != 2'd0);
    assign do_push = push & ((cnt != 2'd2) | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= din;
                    else             slot1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new word lands behind whatever
                    // remains after the head leaves
                    if (cnt == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = slot0;
    assign valid = (cnt != 2'd0);
    assign count = cnt;

endmodule

// File: rtl/dtw_tmpl_fetch.sv
// Template fetch stage: on i_start reads SEQ_LEN consecutive words of
// template i_idx from the single-port synchronous template memory and
// streams them to the DTW core with valid/ready.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_start, i_idx  : start request and template index (sampled in IDLE)
//   bus (master)    : memory port (mem_addr/mem_CS/mem_WR/mem_rdata) and
//                     core stream (o_data/o_valid/o_last/i_ready)
//   o_busy          : high outside IDLE
//   o_done          : pulse the cycle after the last word is accepted
//   o_err           : pulse when the requested template is out of range
module dtw_tmpl_fetch
    import dtw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_idx,
    dtw_tmpl_fetch_if.master bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_q;      // next address to issue
    logic [ADDR_W-1:0] addr_hold;   // last issued address
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  acc_cnt;
    logic              inflight;    // read issued last cycle, data on bus now
    logic              done_q, err_q;

    logic [ADDR_W:0]   base;
    logic [ADDR_W+1:0] last_addr;
    logic              in_range;
    logic              start_go, start_bad;
    logic              issue, pop, last_word;
    logic [2:0]        occ;
    logic [1:0]        fifo_cnt;
    logic              fifo_valid;
    logic [DATA_W-1:0] fifo_dout;

    // full-width base so an out-of-range index cannot alias into memory
    assign base      = (ADDR_W+1)'(i_idx) * (ADDR_W+1)'(SEQ_LEN);
    assign last_addr = {1'b0, base} + (ADDR_W+2)'(SEQ_LEN - 1);
    assign in_range  = last_addr <= (ADDR_W+2)'(MEM_DEPTH - 1);

    assign pop       = fifo_valid & bus.i_ready;
    assign last_word = (acc_cnt == CNT_W'(SEQ_LEN - 1));
    // words that will occupy the buffer after this cycle if no new issue
    assign occ       = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_start && in_range) state_nx = FETCH;
            FETCH:   if (issue && issue_cnt == CNT_W'(SEQ_LEN - 1)) state_nx = DRAIN;
            DRAIN:   if (pop && last_word) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        start_go  = 1'b0;
        start_bad = 1'b0;
        issue     = 1'b0;
        o_busy    = (state != IDLE);
        case (state)
            IDLE: begin
                start_go  = i_start & in_range;
                start_bad = i_start & ~in_range;
            end
            // credit keeps buffer + in-flight within the 2 entries
            FETCH:   issue = (occ <= 3'd1);
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            addr_hold <= '0;
            issue_cnt <= '0;
            acc_cnt   <= '0;
            inflight  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            inflight <= issue;
            done_q   <= (state == DRAIN) & pop & last_word;
            err_q    <= start_bad;
            if (start_go) begin
                addr_q    <= base[ADDR_W-1:0];
                issue_cnt <= '0;
                acc_cnt   <= '0;
            end
            if (issue) begin
                addr_hold <= addr_q;
                addr_q    <= addr_q + 1'b1;
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (pop) acc_cnt <= acc_cnt + 1'b1;
        end
    end

    dtw_skid_fifo #(.W(DATA_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (bus.mem_rdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .count (fifo_cnt)
    );

    // CS must stay low in the capture cycle or the memory releases the bus;
    // the address then repeats the last issue and that extra read is ignored.
    assign bus.mem_CS   = ~(issue | inflight);
    assign bus.mem_addr = issue ? addr_q : addr_hold;
    assign bus.mem_WR   = 1'b0;
    assign bus.o_data   = fifo_dout;
    assign bus.o_valid  = fifo_valid;
    assign bus.o_last   = fifo_valid & last_word;

    assign o_done = done_q;
    assign o_err  = err_q;

endmodule

// File: tb/tb_dtw_tmpl_fetch.sv
module tb_dtw_tmpl_fetch;
    import dtw_pkg::*;

    localparam int MAXC = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [IDX_W-1:0] i_idx;
    logic             o_busy, o_done, o_err;

    dtw_tmpl_fetch_if bus ();

    dtw_tmpl_fetch dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_idx   (i_idx),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    // template memory: word == address, 1-cycle registered read; data is
    // only driven while CS stays low after a request, otherwise the bus
    // floats (modelled as a recognisable junk pattern)
    logic [DATA_W-1:0] rd_q;
    logic              req_q;
    always_ff @(posedge clk) begin
        req_q <= !bus.mem_CS;
        if (!bus.mem_CS) rd_q <= DATA_W'(bus.mem_addr);
    end
    assign bus.mem_rdata = (req_q && !bus.mem_CS) ? rd_q : 32'hDEAD_BEEF;

    int vectors = 0;
    int miscompares = 0;

    // observations of one transfer
    int  words_q[$];
    bit  lasts_q[$];
    int  acc_cyc_q[$];
    int  issue_addr_q[$];
    int  done_cyc, err_cyc, done_cnt, err_cnt;
    int  cs_low_cnt, wr_hi_cnt, issues, max_out, busy_any;
    int  busy_hist[MAXC];
    int  iss_hist[MAXC];
    logic              prev_cs_low;
    logic [ADDR_W-1:0] last_cs_addr;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] s_addr;
    logic s_cs, s_wr, s_valid, s_last, s_busy, s_done, s_err;

    // rmode: 0 ready high, 1 random ready, 2 ready low for [st0, st0+stlen)
    task automatic run_xfer(input int idx, input int rmode, input int st0, input int stlen,
                            input int rs_cyc, input int rst_cyc);
        words_q.delete(); lasts_q.delete(); acc_cyc_q.delete(); issue_addr_q.delete();
        done_cyc = -1; err_cyc = -1; done_cnt = 0; err_cnt = 0;
        cs_low_cnt = 0; wr_hi_cnt = 0; issues = 0; max_out = 0; busy_any = 0;
        prev_cs_low = 1'b0; last_cs_addr = '0;
        for (int c = 0; c < MAXC; c++) begin
            @(posedge clk); #1;
            i_start = (c == 0) || (c == rs_cyc);
            i_idx   = (c == 0) ? IDX_W'(idx) : IDX_W'(idx + 7);
            rst     = (c == rst_cyc);
            if (rmode == 1)      bus.i_ready = 1'($urandom_range(0, 1));
            else if (rmode == 2) bus.i_ready = (c >= st0 && c < st0 + stlen) ? 1'b0 : 1'b1;
            else                 bus.i_ready = 1'b1;
            @(negedge clk);
            if (!bus.mem_CS) begin
                cs_low_cnt++;
                if (!prev_cs_low || bus.mem_addr != last_cs_addr) begin
                    issues++;
                    issue_addr_q.push_back(int'(bus.mem_addr));
                end
            end
            prev_cs_low  = !bus.mem_CS;
            last_cs_addr = bus.mem_addr;
            if (bus.mem_WR) wr_hi_cnt++;
            if (bus.o_valid && bus.i_ready) begin
                words_q.push_back(int'(bus.o_data));
                lasts_q.push_back(bus.o_last);
                acc_cyc_q.push_back(c);
            end
            if (o_done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (o_err)  begin err_cnt++;  if (err_cyc < 0)  err_cyc = c;  end
            if (o_busy) busy_any = 1;
            busy_hist[c] = int'(o_busy);
            iss_hist[c]  = issues;
            if (issues - words_q.size() > max_out) max_out = issues - words_q.size();
            if (rst_cyc >= 0 && c == rst_cyc + 1) begin
                s_data = bus.o_data; s_addr = bus.mem_addr; s_cs = bus.mem_CS; s_wr = bus.mem_WR;
                s_valid = bus.o_valid; s_last = bus.o_last; s_busy = o_busy;
                s_done = o_done; s_err = o_err;
                break;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
            if (err_cyc >= 0 && c >= err_cyc + 3) break;
        end
        @(posedge clk); #1;
        i_start = 1'b0; rst = 1'b0; bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_idx = '0; bus.i_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.mem_CS, bus.mem_WR, bus.mem_addr} !== {1'b1, 1'b0, 10'd0}) begin
            miscompares++;
            $display("FAIL reset_mem: got CS=%b WR=%b addr=%0d want CS=1 WR=0 addr=0",
                     bus.mem_CS, bus.mem_WR, bus.mem_addr);
        end
        vectors++;
        if ({bus.o_data, bus.o_valid, bus.o_last} !== {32'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_stream: got data=%0h valid=%b last=%b want 0/0/0",
                     bus.o_data, bus.o_valid, bus.o_last);
        end
        vectors++;
        if ({o_busy, o_done, o_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got busy/done/err=%b%b%b want 000", o_busy, o_done, o_err);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nominal(input int idx);
        int base = idx * SEQ_LEN;
        run_xfer(idx, 0, 0, 0, -1, -1);
        vectors++;
        if (words_q.size() != SEQ_LEN) begin
            miscompares++;
            $display("FAIL nominal_count idx=%0d: got %0d words want %0d", idx, words_q.size(), SEQ_LEN);
        end
        for (int k = 0; k < words_q.size() && k < SEQ_LEN; k++) begin
            vectors++;
            if (words_q[k] != base + k || acc_cyc_q[k] != 3 + k || lasts_q[k] != (k == SEQ_LEN - 1)) begin
                miscompares++;
                $display("FAIL nominal_word[%0d]: got data=%0d cyc=%0d last=%0d want data=%0d cyc=%0d last=%0d",
                         k, words_q[k], acc_cyc_q[k], lasts_q[k], base + k, 3 + k, int'(k == SEQ_LEN - 1));
            end
        end
        vectors++;
        if (done_cyc != 23 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL nominal_done: got cycle %0d count %0d want cycle 23 count 1", done_cyc, done_cnt);
        end
        vectors++;
        if (busy_hist[0] != 0 || busy_hist[1] != 1 || busy_hist[22] != 1 || busy_hist[23] != 0) begin
            miscompares++;
            $display("FAIL nominal_busy: got c0=%0d c1=%0d c22=%0d c23=%0d want 0 1 1 0",
                     busy_hist[0], busy_hist[1], busy_hist[22], busy_hist[23]);
        end
        vectors++;
        if (wr_hi_cnt != 0 || err_cnt != 0) begin
            miscompares++;
            $display("FAIL nominal_wr_err: got WR-high %0d err %0d want 0 0", wr_hi_cnt, err_cnt);
        end
        vectors++;
        if (issue_addr_q.size() != SEQ_LEN || issue_addr_q[0] != base || issue_addr_q[issue_addr_q.size()-1] != base + SEQ_LEN - 1) begin
            miscompares++;
            $display("FAIL nominal_issues: got %0d issues want %0d from %0d", issue_addr_q.size(), SEQ_LEN, base);
        end
    endtask

    task automatic test_out_of_range();
        run_xfer(51, 0, 0, 0, -1, -1);
        vectors++;
        if (err_cyc != 1 || err_cnt != 1) begin
            miscompares++;
            $display("FAIL oor_err: got cycle %0d count %0d want cycle 1 count 1", err_cyc, err_cnt);
        end
        vectors++;
        if (cs_low_cnt != 0 || busy_any != 0 || words_q.size() != 0 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL oor_quiet: got CS-low %0d busy %0d words %0d done %0d want all 0",
                     cs_low_cnt, busy_any, words_q.size(), done_cnt);
        end
    endtask

    // checks the stream is exactly base..base+SEQ_LEN-1 and the error state matches range
    task automatic test_random_ready(input int idx);
        int base = idx * SEQ_LEN;
        bit ok_range = (base + SEQ_LEN - 1) <= MEM_DEPTH - 1;
        int nwant = ok_range ? SEQ_LEN : 0;
        run_xfer(idx, 1, 0, 0, -1, -1);
        vectors++;
        if (words_q.size() != nwant || (err_cnt != 0) == ok_range || (done_cnt == 1) != ok_range) begin
            miscompares++;
            $display("FAIL rand_status idx=%0d: got words %0d err %0d done %0d want words %0d in-range %0d",
                     idx, words_q.size(), err_cnt, done_cnt, nwant, int'(ok_range));
        end
        for (int k = 0; k < words_q.size() && k < nwant; k++) begin
            vectors++;
            if (words_q[k] != base + k || lasts_q[k] != (k == SEQ_LEN - 1)) begin
                miscompares++;
                $display("FAIL rand_word idx=%0d [%0d]: got %0d last %0d want %0d last %0d",
                         idx, k, words_q[k], lasts_q[k], base + k, int'(k == SEQ_LEN - 1));
            end
        end
        vectors++;
        if (max_out > 3) begin
            miscompares++;
            $display("FAIL rand_outstanding idx=%0d: got %0d want <= 3", idx, max_out);
        end
    endtask

    task automatic test_backpressure();
        int base = 5 * SEQ_LEN;
        run_xfer(5, 2, 4, 10, -1, -1);
        vectors++;
        if (words_q.size() != SEQ_LEN) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words want %0d", words_q.size(), SEQ_LEN);
        end
        for (int k = 0; k < words_q.size() && k < SEQ_LEN; k++) begin
            vectors++;
            if (words_q[k] != base + k || acc_cyc_q[k] != ((k == 0) ? 3 : 13 + k)) begin
                miscompares++;
                $display("FAIL bp_word[%0d]: got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, words_q[k], acc_cyc_q[k], base + k, (k == 0) ? 3 : 13 + k);
            end
        end
        // stalled: one word taken, two buffered, no further issues
        vectors++;
        if (iss_hist[7] != 3 || iss_hist[13] != 3) begin
            miscompares++;
            $display("FAIL bp_stall: got issues c7=%0d c13=%0d want 3 3", iss_hist[7], iss_hist[13]);
        end
        vectors++;
        if (done_cyc != 33) begin
            miscompares++;
            $display("FAIL bp_done: got cycle %0d want 33", done_cyc);
        end
    endtask

    task automatic test_restart_ignored();
        run_xfer(2, 0, 0, 0, 10, -1);
        vectors++;
        if (words_q.size() != SEQ_LEN || words_q[0] != 40 || words_q[words_q.size()-1] != 59 ||
            done_cyc != 23 || err_cnt != 0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL restart: got words %0d done %0d/%0d err %0d want 20 words 40..59 done 23 err 0",
                     words_q.size(), done_cyc, done_cnt, err_cnt);
        end
        for (int k = 0; k < words_q.size() && k < SEQ_LEN; k++) begin
            vectors++;
            if (words_q[k] != 40 + k) begin
                miscompares++;
                $display("FAIL restart_word[%0d]: got %0d want %0d", k, words_q[k], 40 + k);
            end
        end
    endtask

    task automatic test_rst_mid();
        run_xfer(4, 0, 0, 0, -1, 12);
        for (int k = 0; k < words_q.size(); k++) begin
            vectors++;
            if (words_q[k] != 80 + k) begin
                miscompares++;
                $display("FAIL rstmid_word[%0d]: got %0d want %0d", k, words_q[k], 80 + k);
            end
        end
        vectors++;
        if ({s_cs, s_wr, s_addr, s_data, s_valid, s_last, s_busy, s_done, s_err} !==
            {1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rstmid_state: got CS=%b WR=%b addr=%0d data=%0h v=%b l=%b busy=%b done=%b err=%b want reset values",
                     s_cs, s_wr, s_addr, s_data, s_valid, s_last, s_busy, s_done, s_err);
        end
        test_nominal(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal(3);
        test_nominal(50);
        test_out_of_range();
        test_random_ready(0);
        test_backpressure();
        test_restart_ignored();
        test_rst_mid();
        for (int n = 0; n < 6; n++) test_random_ready(int'($urandom_range(0, 63)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
